// File: rtl/stopwatch_core.sv
// Stopwatch run control and BCD time base (SS.hh, 00.00-99.99).
// Debounced button levels are turned into single-cycle events; a prescaler
// divides clk down to 1/100 s ticks that advance a 4-digit BCD counter.
module stopwatch_core #(
    parameter int unsigned TICK_DIV = 500000,
    parameter int unsigned PW       = 19
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        stop,
    output logic [15:0] digits,
    output logic        running,
    output logic        overflow
);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StStop} state_e;

    localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);

    state_e        state_q, state_d;
    logic          start_q, pause_q, stop_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   digits_q, digits_d;
    logic [15:0]   digits_inc;
    logic          digits_carry;
    logic          overflow_q, overflow_d;
    logic          running_q;
    logic          start_raw, pause_raw, stop_raw;
    logic          start_ev, pause_ev, stop_ev;
    logic          tick;

    // Rising-edge events with priority stop > pause > start; losers are dropped.
    always_comb begin
        start_raw = start & ~start_q;
        pause_raw = pause & ~pause_q;
        stop_raw  = stop & ~stop_q;
        stop_ev   = stop_raw;
        pause_ev  = pause_raw & ~stop_raw;
        start_ev  = start_raw & ~pause_raw & ~stop_raw;
    end

    assign tick = (state_q == StRun) && (presc_q == PrescMax);

    // BCD increment by one hundredth; carry out of the top digit means 99.99 wrapped.
    always_comb begin
        digits_inc   = digits_q;
        digits_carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (digits_carry) begin
                if (digits_q[4*i +: 4] == 4'd9) begin
                    digits_inc[4*i +: 4] = 4'd0;
                end else begin
                    digits_inc[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
                    digits_carry         = 1'b0;
                end
            end
        end
    end

    // Next-state, prescaler and counter update.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        digits_d   = digits_q;
        overflow_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_ev) begin
                    state_d  = StRun;
                    presc_d  = '0;
                    digits_d = '0;
                end
            end
            StRun: begin
                // The tick lands even if an event leaves RUN on this same edge.
                if (tick) begin
                    presc_d    = '0;
                    digits_d   = digits_inc;
                    overflow_d = digits_carry;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
                if (stop_ev) begin
                    state_d = StStop;
                end else if (pause_ev) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                // Prescaler is left untouched so the resumed tick keeps its phase.
                if (stop_ev) begin
                    state_d = StStop;
                end else if (pause_ev || start_ev) begin
                    state_d = StRun;
                end
            end
            StStop: begin
                if (start_ev) begin
                    state_d  = StRun;
                    presc_d  = '0;
                    digits_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            pause_q    <= 1'b0;
            stop_q     <= 1'b0;
            presc_q    <= '0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            pause_q    <= pause;
            stop_q     <= stop;
            presc_q    <= presc_d;
            digits_q   <= digits_d;
            overflow_q <= overflow_d;
            running_q  <= (state_d == StRun);
        end
    end

    assign digits   = digits_q;
    assign running  = running_q;
    assign overflow = overflow_q;

endmodule
